// File: rtl/key_input_ctrl_pkg.sv
// Shared constants and types for the push-button input block.
// Provides key index names, default timing constants, the auto-repeat
// state encoding and a counter-width helper.
package key_input_pkg;

    localparam int unsigned KEY_UP   = 0;
    localparam int unsigned KEY_DOWN = 1;

    // Defaults assume a 50 MHz clock.
    localparam int unsigned DEF_N_KEYS          = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000; // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;  // 100 ms

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    // Width of a counter that runs 0 .. v-1 (minimum 1 bit).
    function automatic int unsigned cnt_width(input int unsigned v);
        return $clog2((v < 2) ? 2 : v);
    endfunction

endpackage

// File: rtl/key_input_ctrl_if.sv
// Signal bundle between the push-button block and its user.
//   key_n       raw active-low button pins (into the block)
//   key_level   debounced level, 1 = pressed
//   key_press   1-cycle pulse on accepted press
//   key_release 1-cycle pulse on accepted release
//   key_repeat  1-cycle pulse per auto-repeat while held
//   position    current bar position 0..7
//   leds        one-hot LED bar, 8'b1 << position
// slave = the block itself, master = whoever drives the pins / reads results.
interface key_input_ctrl_if #(
    parameter int unsigned N_KEYS = 2
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_repeat;
    logic [2:0]        position;
    logic [7:0]        leds;

    modport master (
        output key_n,
        input  key_level, key_press, key_release, key_repeat, position, leds
    );

    modport slave (
        input  key_n,
        output key_level, key_press, key_release, key_repeat, position, leds
    );
endinterface

// File: rtl/key_input_ctrl_debounce.sv
// One push button: 2-FF synchroniser, debounce counter, press/release
// pulses and the auto-repeat state machine.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   key_n        raw active-low pin, asynchronous to clk
//   key_level    debounced level, 1 = pressed
//   key_press    1-cycle pulse in the first cycle key_level reads 1
//   key_release  1-cycle pulse in the first cycle key_level reads 0
//   key_repeat   1-cycle auto-repeat pulse while held
module key_debounce
    import key_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int unsigned DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RP_W    = cnt_width(RPT_MAX);
    localparam bit          RPT_EN  = (REPEAT_DELAY != 0);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DLY_LAST = RP_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PER_LAST = RP_W'(REPEAT_PERIOD - 1);

    logic            sync1, sync2;
    logic            pressed;
    logic [DB_W-1:0] db_cnt;
    rpt_state_t      state, state_nx;
    logic [RP_W-1:0] rcnt, rcnt_nx;

    // Sync flops reset to 1 so a held key is seen as released after reset
    // and must debounce again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    // Level is accepted after DEBOUNCE_CYCLES consecutive disagreeing
    // samples; the pulses are registered alongside the level so they
    // line up with its first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt      <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (pressed == key_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt      <= '0;
                key_level   <= pressed;
                key_press   <= pressed;
                key_release <= ~pressed;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RPT_IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nx;
            rcnt  <= rcnt_nx;
        end
    end

    // rcnt counts cycles since the press cycle (DELAY) or since the last
    // repeat (REPEAT); the pulse fires in the cycle the count hits its end.
    always_comb begin
        state_nx   = state;
        rcnt_nx    = rcnt;
        key_repeat = 1'b0;
        if (key_release) begin
            state_nx = RPT_IDLE;
            rcnt_nx  = '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (key_press && RPT_EN) begin
                        state_nx = RPT_DELAY;
                        rcnt_nx  = '0;
                    end
                end
                RPT_DELAY: begin
                    if (rcnt == DLY_LAST) begin
                        key_repeat = 1'b1;
                        state_nx   = RPT_REPEAT;
                        rcnt_nx    = '0;
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (rcnt == PER_LAST) begin
                        key_repeat = 1'b1;
                        rcnt_nx    = '0;
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = RPT_IDLE;
                    rcnt_nx  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_input_ctrl.sv
// Push-button front end for the DE0-Nano LED bar.
// Each key is synchronised, debounced and turned into press/release/
// auto-repeat pulses; KEY_UP/KEY_DOWN events move a saturating 3-bit
// position shown as a one-hot 8-LED bar. Keys beyond index 1 are
// debounced and pulsed but do not move the position.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  key_input_ctrl_if.slave: key_n in; key_level, key_press,
//        key_release, key_repeat, position, leds out
module key_input_ctrl
    import key_input_pkg::*;
#(
    parameter int unsigned N_KEYS          = DEF_N_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input logic             clk,
    input logic             rst,
    key_input_ctrl_if.slave bus
);

    logic       up_evt, down_evt;
    logic [2:0] pos;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_key (
            .clk         (clk),
            .rst         (rst),
            .key_n       (bus.key_n[i]),
            .key_level   (bus.key_level[i]),
            .key_press   (bus.key_press[i]),
            .key_release (bus.key_release[i]),
            .key_repeat  (bus.key_repeat[i])
        );
    end

    assign up_evt   = bus.key_press[KEY_UP]   | bus.key_repeat[KEY_UP];
    assign down_evt = bus.key_press[KEY_DOWN] | bus.key_repeat[KEY_DOWN];

    // Simultaneous up and down cancel; both ends saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (up_evt && !down_evt && pos != 3'd7) begin
            pos <= pos + 3'd1;
        end else if (down_evt && !up_evt && pos != 3'd0) begin
            pos <= pos - 3'd1;
        end
    end

    always_comb begin
        bus.position = pos;
        bus.leds     = 8'b1 << pos;
    end

endmodule
